axis_prbs_frame_checker: RTL and testbench
==========================================

Name: axis_prbs_frame_checker

Overview:
- Sits directly downstream of the PAM receiver's AXI-stream output (demodulated, packed symbol bits).
- Compares every received frame against a locally generated PRBS-15 reference, reseeded at each frame start, the same way the transmitter generates payload.
- Produces per-frame bit-error counts, frame-length violations and saturating running statistics for BER measurement on the VLC link.

Parameters:
- WIDTH_AXI_DATA, 32, stream data width; must be a multiple of 8.
- LENGTH_DATA, 1024, PAM symbols per frame.
- PAM_ORDER, 4, PAM order; bits per symbol = log2(PAM_ORDER).
- PRBS_SEED, 15'h7FFF, LFSR seed loaded at reset and at every frame start; must be non-zero.
- WIDTH_STAT, 32, width of the running statistic counters.

Ports:
- clk  in  1  system clock
- arst_n  in  1  asynchronous active-low reset
- s_axi_tvalid  in  1  upstream beat valid
- s_axi_tready  out  1  checker ready
- s_axi_tdata  in  WIDTH_AXI_DATA  packed bits, LSB = earliest bit
- s_axi_tkeep  in  WIDTH_AXI_DATA/8  byte enables; a 0 masks that byte from comparison
- s_axi_tlast  in  1  last beat of frame
- clr_stats  in  1  synchronous clear of the running totals
- frame_done  out  1  one-cycle pulse; per-frame results valid
- frame_err_bits  out  16  bit errors in the last completed frame (saturating)
- frame_len_err  out  1  last completed frame had the wrong beat count
- total_frames  out  WIDTH_STAT  frames completed
- total_err_bits  out  WIDTH_STAT  accumulated bit errors
- err_frames  out  WIDTH_STAT  frames with frame_err_bits != 0 or frame_len_err

Behaviour:
- One clock domain. arst_n is asynchronous and active-low. Reset is asserted asynchronously and released synchronously to clk.
- Reset values: all outputs 0, including s_axi_tready. The LFSR is loaded with PRBS_SEED and the state machine is in RUN. s_axi_tready rises on the first clock edge after reset release.
- Frame geometry: WORDS = LENGTH_DATA*log2(PAM_ORDER)/WIDTH_AXI_DATA, which is 64 at the defaults.
- PRBS-15 polynomial is x^15+x^14+1. Each accepted beat advances the LFSR by WIDTH_AXI_DATA steps, produced by a combinational unrolled generator. Bit i of the reference word is the i-th generated bit.
- Handshake: a beat transfers when tvalid && tready. tvalid gaps are allowed anywhere in a frame; the LFSR and beat counter advance only on a transfer.
- State machine, 3 states:
  - RUN: tready=1. Each transfer does three things: (a) registers err_vec = (tdata ^ ref) & byte_mask(tkeep); (b) increments beat_idx; (c) on tlast, goes to DRAIN.
  - DRAIN: tready=0. popcount(err_vec) is added to the frame accumulator. Next state is REPORT.
  - REPORT: tready=0. frame_done=1 for this single cycle and the outputs/totals update. The LFSR reloads PRBS_SEED, beat_idx and the accumulator clear, and the state returns to RUN.
- Pipeline and latency: each RUN transfer's popcount is accumulated on the following edge. For a tlast transfer at edge k, frame_done is high in the cycle after edge k+2. tready is low for exactly 2 cycles between frames.
- Length check: frame_len_err = (beat index of the tlast beat != WORDS-1). Beats with index >= WORDS are not compared; they affect only the length check. beat_idx saturates at WORDS.
- Arithmetic: the popcount is WIDTH_AXI_DATA wide, summed into a 16-bit frame accumulator that saturates at 16'hFFFF. total_err_bits adds frame_err_bits and saturates at all-ones; total_frames and err_frames also saturate.
- clr_stats clears total_frames, total_err_bits and err_frames on the next edge. If it coincides with REPORT, the clear wins and that frame is not added. Per-frame outputs are not affected by clr_stats.
- Per-frame outputs hold their values until the next REPORT.
- Reset mid-frame: everything is abandoned immediately and no frame_done is issued.

Decomposition:
- Package vlc_rx_pkg holds: WORDS and bits-per-symbol derivation functions, PRBS-15 tap constants, default seed, and state encoding (RUN, DRAIN, REPORT).
- One sub-module, prbs15_word_gen: takes the LFSR state and produces the next WIDTH_AXI_DATA reference bits plus the advanced state. It is purely combinational and unit-tested on its own.

Test Plan:
- Reset: hold arst_n low with tvalid=1 -> tready=0 and all stats 0; tready=1 on the first edge after release.
- Clean frame: 64 correct PRBS words, tlast on word 63 -> frame_done 2 cycles after the tlast transfer edge, frame_err_bits=0, frame_len_err=0, total_frames=1, err_frames=0.
- Errors: flip bit 0 of word 0 and bits 31..28 of word 63 -> frame_err_bits=5, total_err_bits=5, err_frames=1. A following clean frame gives frame_err_bits=0 and total_err_bits still 5, which proves the reseed.
- Short frame: correct data with tlast on word 39 -> frame_len_err=1, frame_err_bits=0, err_frames+1. Next 64-word frame is clean.
- Masking: word 10 corrupted in bytes 1..3 with tkeep=4'b0001 -> frame_err_bits=0. Same word with tkeep=4'b1111 -> 24 if all 24 bits are inverted.
- Gaps and clear: random tvalid gaps inside the frame give results identical to the gap-free case. clr_stats asserted in the REPORT cycle -> totals read 0 afterwards, frame_err_bits still shows that frame.

Source files
------------

// File: rtl/vlc_rx_pkg.sv
// Shared definitions for the VLC receive path: frame geometry helpers,
// PRBS-15 generator constants and the frame checker state encoding.
package vlc_rx_pkg;

    // x^15 + x^14 + 1 : feedback taps are the two oldest LFSR stages
    localparam int          PRBS15_TAP_HI       = 14;
    localparam int          PRBS15_TAP_LO       = 13;
    localparam logic [14:0] PRBS15_SEED_DEFAULT = 15'h7FFF;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        REPORT = 2'd2
    } chk_state_t;

    function automatic int bits_per_symbol(input int pam_order);
        return $clog2(pam_order);
    endfunction

    function automatic int frame_words(input int length_data, input int pam_order,
                                       input int width);
        return length_data * bits_per_symbol(pam_order) / width;
    endfunction

endpackage

// File: rtl/prbs15_word_gen.sv
// Unrolled PRBS-15 generator: emits WIDTH reference bits (bit 0 first)
// and the LFSR state after WIDTH steps. Purely combinational.
module prbs15_word_gen
    import vlc_rx_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [14:0]      state_in,
    output logic [WIDTH-1:0] ref_bits,
    output logic [14:0]      state_out
);

    logic [14:0] s;
    logic        fb;

    // Step the Fibonacci LFSR WIDTH times; each feedback bit is the next output bit
    always_comb begin
        s        = state_in;
        fb       = 1'b0;
        ref_bits = '0;
        for (int i = 0; i < WIDTH; i++) begin
            fb          = s[PRBS15_TAP_HI] ^ s[PRBS15_TAP_LO];
            ref_bits[i] = fb;
            s           = {s[13:0], fb};
        end
        state_out = s;
    end

endmodule

// File: rtl/axis_prbs_frame_checker.sv
// AXI-stream PRBS-15 frame checker: compares each frame against a reseeded
// reference, reports per-frame bit errors / length violations and keeps
// saturating running totals for BER measurement.
module axis_prbs_frame_checker
    import vlc_rx_pkg::*;
#(
    parameter int          WIDTH_AXI_DATA = 32,
    parameter int          LENGTH_DATA    = 1024,
    parameter int          PAM_ORDER      = 4,
    parameter logic [14:0] PRBS_SEED      = PRBS15_SEED_DEFAULT,
    parameter int          WIDTH_STAT     = 32
) (
    input  logic                        clk,
    input  logic                        arst_n,
    input  logic                        s_axi_tvalid,
    output logic                        s_axi_tready,
    input  logic [WIDTH_AXI_DATA-1:0]   s_axi_tdata,
    input  logic [WIDTH_AXI_DATA/8-1:0] s_axi_tkeep,
    input  logic                        s_axi_tlast,
    input  logic                        clr_stats,
    output logic                        frame_done,
    output logic [15:0]                 frame_err_bits,
    output logic                        frame_len_err,
    output logic [WIDTH_STAT-1:0]       total_frames,
    output logic [WIDTH_STAT-1:0]       total_err_bits,
    output logic [WIDTH_STAT-1:0]       err_frames
);

    localparam int               KEEP_W   = WIDTH_AXI_DATA / 8;
    localparam int               WORDS    = frame_words(LENGTH_DATA, PAM_ORDER, WIDTH_AXI_DATA);
    localparam int               IDX_W    = $clog2(WORDS + 1);
    localparam int               POP_W    = $clog2(WIDTH_AXI_DATA + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
    localparam logic [IDX_W-1:0] SAT_IDX  = IDX_W'(WORDS);

    chk_state_t                state, state_nxt;
    logic [14:0]               lfsr, lfsr_nxt;
    logic [WIDTH_AXI_DATA-1:0] ref_word, byte_mask, err_vec;
    logic [IDX_W-1:0]          beat_idx;
    logic [15:0]               acc;
    logic [16:0]               acc_sum;
    logic [POP_W-1:0]          pop;
    logic [WIDTH_STAT:0]       tot_sum;
    logic                      len_bad, xfer, frame_bad;

    prbs15_word_gen #(.WIDTH(WIDTH_AXI_DATA)) u_gen (
        .state_in (lfsr),
        .ref_bits (ref_word),
        .state_out(lfsr_nxt)
    );

    assign xfer      = s_axi_tvalid && s_axi_tready;
    assign frame_bad = (acc != 16'd0) || len_bad;
    assign tot_sum   = {1'b0, total_err_bits} + (WIDTH_STAT+1)'(acc);

    // Expand byte enables into a per-bit compare mask
    always_comb begin
        byte_mask = '0;
        for (int b = 0; b < KEEP_W; b++) byte_mask[b*8 +: 8] = {8{s_axi_tkeep[b]}};
    end

    // Popcount of the registered error vector and the saturating frame sum
    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH_AXI_DATA; i++) pop = pop + POP_W'(err_vec[i]);
        acc_sum = {1'b0, acc} + 17'(pop);
    end

    // Next-state logic: RUN until tlast, then one drain and one report cycle
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (xfer && s_axi_tlast) state_nxt = DRAIN;
            DRAIN:   state_nxt = REPORT;
            REPORT:  state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // State register; tready is registered so it stays low through reset
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state        <= RUN;
            s_axi_tready <= 1'b0;
        end else begin
            state        <= state_nxt;
            s_axi_tready <= (state_nxt == RUN);
        end
    end

    // Compare datapath: LFSR advance, beat counting, error vector and accumulation
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            lfsr     <= PRBS_SEED;
            beat_idx <= '0;
            err_vec  <= '0;
            acc      <= '0;
            len_bad  <= 1'b0;
        end else if (state == REPORT) begin
            lfsr     <= PRBS_SEED;
            beat_idx <= '0;
            err_vec  <= '0;
            acc      <= '0;
            len_bad  <= 1'b0;
        end else begin
            acc     <= acc_sum[16] ? 16'hFFFF : acc_sum[15:0];
            err_vec <= '0;
            if (xfer) begin
                lfsr <= lfsr_nxt;
                // beats past the nominal frame only feed the length check
                if (beat_idx != SAT_IDX) begin
                    err_vec  <= (s_axi_tdata ^ ref_word) & byte_mask;
                    beat_idx <= beat_idx + IDX_W'(1);
                end
                if (s_axi_tlast) len_bad <= (beat_idx != LAST_IDX);
            end
        end
    end

    // Per-frame results and saturating totals, published at the end of REPORT
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            frame_done     <= 1'b0;
            frame_err_bits <= '0;
            frame_len_err  <= 1'b0;
            total_frames   <= '0;
            total_err_bits <= '0;
            err_frames     <= '0;
        end else begin
            frame_done <= (state == REPORT);
            if (state == REPORT) begin
                frame_err_bits <= acc;
                frame_len_err  <= len_bad;
            end
            if (clr_stats) begin
                total_frames   <= '0;
                total_err_bits <= '0;
                err_frames     <= '0;
            end else if (state == REPORT) begin
                if (total_frames != '1) total_frames <= total_frames + 1'b1;
                total_err_bits <= tot_sum[WIDTH_STAT] ? '1 : tot_sum[WIDTH_STAT-1:0];
                if (frame_bad && (err_frames != '1)) err_frames <= err_frames + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis_prbs_frame_checker.sv
// Self-checking bench for axis_prbs_frame_checker: reference PRBS bit stream
// from the recurrence b[n] = b[n-15] ^ b[n-14], frame-level error model.
module tb_axis_prbs_frame_checker;

    localparam int W = 32, KW = 4, WORDS = 64, MAXW = 80, NB = MAXW * W;

    logic clk = 1'b0, arst_n = 1'b0;
    logic tvalid = 1'b0, tready, tlast = 1'b0, clr_stats = 1'b0;
    logic [W-1:0]  tdata = '0;
    logic [KW-1:0] tkeep = '1;
    logic          frame_done, frame_len_err;
    logic [15:0]   frame_err_bits;
    logic [31:0]   total_frames, total_err_bits, err_frames;
    logic [14:0]   g_state = 15'h7FFF, g_next;
    logic [W-1:0]  g_bits;

    int checks = 0, errors = 0;
    bit prbs_bits[NB];
    logic [W-1:0]  flip[MAXW];
    logic [KW-1:0] keep[MAXW];
    int m_frames = 0, m_err_bits = 0, m_err_frames = 0;
    int exp_err, obs_lat, obs_low;
    bit exp_len;
    logic obs_pulse2, obs_len;
    logic [15:0] obs_err;

    always #5 clk = ~clk;

    axis_prbs_frame_checker dut (
        .clk(clk), .arst_n(arst_n),
        .s_axi_tvalid(tvalid), .s_axi_tready(tready), .s_axi_tdata(tdata),
        .s_axi_tkeep(tkeep), .s_axi_tlast(tlast), .clr_stats(clr_stats),
        .frame_done(frame_done), .frame_err_bits(frame_err_bits),
        .frame_len_err(frame_len_err), .total_frames(total_frames),
        .total_err_bits(total_err_bits), .err_frames(err_frames)
    );

    prbs15_word_gen #(.WIDTH(W)) u_gen (.state_in(g_state), .ref_bits(g_bits), .state_out(g_next));

    function automatic logic [W-1:0] model_word(input int w);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = prbs_bits[w*W + i];
        return r;
    endfunction

    function automatic int kept_errs(input int w);
        logic [W-1:0] m;
        for (int b = 0; b < KW; b++) m[b*8 +: 8] = {8{keep[w][b]}};
        return $countones(flip[w] & m);
    endfunction

    task automatic build_prbs();
        bit hist[NB + 15];
        logic [14:0] seed = 15'h7FFF;
        for (int j = 0; j < 15; j++) hist[j] = seed[14 - j];
        for (int n = 0; n < NB; n++) begin
            hist[n + 15] = hist[n] ^ hist[n + 1];
            prbs_bits[n] = hist[n + 15];
        end
    endtask

    task automatic clear_pattern();
        for (int w = 0; w < MAXW; w++) begin flip[w] = '0; keep[w] = '1; end
    endtask

    task automatic put_beat(input logic [W-1:0] d, input logic [KW-1:0] k, input logic l);
        int n = 0;
        tvalid = 1'b1; tdata = d; tkeep = k; tlast = l;
        while (!tready && n < 50) begin @(posedge clk); #1; n++; end
        if (!tready) begin
            checks++; errors++;
            $display("FAIL beat_timeout tready stayed %b exp 1", tready);
        end
        @(posedge clk); #1;
        tvalid = 1'b0; tlast = 1'b0;
    endtask

    // Drive a frame, update the model, and capture the report observations
    task automatic send_frame(input int nwords, input int gap_pct, input bit clr);
        exp_err = 0;
        for (int w = 0; w < nwords; w++) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct)
                repeat ($urandom_range(1, 4)) begin @(posedge clk); #1; end
            put_beat(model_word(w) ^ flip[w], keep[w], w == nwords - 1);
            if (w < WORDS) exp_err += kept_errs(w);
        end
        exp_len = (nwords != WORDS);
        if (clr) begin m_frames = 0; m_err_bits = 0; m_err_frames = 0; end
        else begin
            m_frames++; m_err_bits += exp_err;
            if (exp_err != 0 || exp_len) m_err_frames++;
        end
        obs_lat = 0; obs_low = 0;
        while (obs_lat < 10) begin
            @(negedge clk); obs_lat++;
            if (frame_done) break;
            if (!tready) obs_low++;
            if (clr && obs_lat == 2) clr_stats = 1'b1;
        end
        clr_stats = 1'b0;
        obs_err = frame_err_bits; obs_len = frame_len_err;
        @(negedge clk); obs_pulse2 = frame_done;
    endtask

    task automatic test_reset();
        arst_n = 1'b0; tvalid = 1'b1; tdata = $urandom;
        repeat (3) @(posedge clk); #1;
        checks++; if (tready !== 1'b0) begin errors++; $display("FAIL reset_tready got %b exp 0", tready); end
        checks++; if ({frame_done, frame_len_err, frame_err_bits} !== 18'd0) begin errors++; $display("FAIL reset_frame_outs got %h exp 0", {frame_done, frame_len_err, frame_err_bits}); end
        checks++; if ({total_frames, total_err_bits, err_frames} !== 96'd0) begin errors++; $display("FAIL reset_totals got %h exp 0", {total_frames, total_err_bits, err_frames}); end
        tvalid = 1'b0;
        @(negedge clk); arst_n = 1'b1; #1;
        checks++; if (tready !== 1'b0) begin errors++; $display("FAIL release_tready_early got %b exp 0", tready); end
        @(posedge clk); #1;
        checks++; if (tready !== 1'b1) begin errors++; $display("FAIL release_tready got %b exp 1", tready); end
    endtask

    task automatic test_gen();
        g_state = 15'h7FFF; #1;
        checks++; if (g_bits !== model_word(0)) begin errors++; $display("FAIL gen_word0 got %h exp %h", g_bits, model_word(0)); end
        g_state = g_next; #1;
        checks++; if (g_bits !== model_word(1)) begin errors++; $display("FAIL gen_word1 got %h exp %h", g_bits, model_word(1)); end
    endtask

    task automatic test_clean();
        clear_pattern();
        send_frame(WORDS, 0, 1'b0);
        checks++; if (obs_lat !== 3) begin errors++; $display("FAIL clean_latency got %0d exp 3", obs_lat); end
        checks++; if (obs_low !== 2) begin errors++; $display("FAIL clean_tready_low got %0d exp 2", obs_low); end
        checks++; if (obs_pulse2 !== 1'b0) begin errors++; $display("FAIL clean_pulse_width got %b exp 0", obs_pulse2); end
        checks++; if ({obs_len, obs_err} !== 17'd0) begin errors++; $display("FAIL clean_result got len %b err %0d exp 0 0", obs_len, obs_err); end
        checks++; if (total_frames !== 32'(m_frames) || err_frames !== 32'(m_err_frames)) begin errors++; $display("FAIL clean_totals got %0d/%0d exp %0d/%0d", total_frames, err_frames, m_frames, m_err_frames); end
    endtask

    task automatic test_errors();
        clear_pattern();
        flip[0] = 32'h0000_0001; flip[63] = 32'hF000_0000;
        send_frame(WORDS, 0, 1'b0);
        checks++; if (obs_err !== 16'd5) begin errors++; $display("FAIL errors_bits got %0d exp 5", obs_err); end
        checks++; if (total_err_bits !== 32'(m_err_bits) || err_frames !== 32'(m_err_frames)) begin errors++; $display("FAIL errors_totals got %0d/%0d exp %0d/%0d", total_err_bits, err_frames, m_err_bits, m_err_frames); end
        clear_pattern();
        send_frame(WORDS, 0, 1'b0);
        checks++; if (obs_err !== 16'd0) begin errors++; $display("FAIL reseed_bits got %0d exp 0", obs_err); end
        checks++; if (total_err_bits !== 32'(m_err_bits)) begin errors++; $display("FAIL reseed_total got %0d exp %0d", total_err_bits, m_err_bits); end
    endtask

    task automatic test_short();
        clear_pattern();
        send_frame(40, 0, 1'b0);
        checks++; if (obs_len !== 1'b1 || obs_err !== 16'd0) begin errors++; $display("FAIL short_result got len %b err %0d exp 1 0", obs_len, obs_err); end
        checks++; if (err_frames !== 32'(m_err_frames)) begin errors++; $display("FAIL short_err_frames got %0d exp %0d", err_frames, m_err_frames); end
        send_frame(WORDS, 0, 1'b0);
        checks++; if (obs_len !== 1'b0 || obs_err !== 16'd0) begin errors++; $display("FAIL after_short got len %b err %0d exp 0 0", obs_len, obs_err); end
        flip[66] = 32'h0000_FFFF;
        send_frame(70, 0, 1'b0);
        checks++; if (obs_len !== 1'b1 || obs_err !== 16'(exp_err)) begin errors++; $display("FAIL long_result got len %b err %0d exp 1 %0d", obs_len, obs_err, exp_err); end
    endtask

    task automatic test_mask();
        clear_pattern();
        flip[10] = 32'hFFFF_FF00; keep[10] = 4'b0001;
        send_frame(WORDS, 0, 1'b0);
        checks++; if (obs_err !== 16'd0) begin errors++; $display("FAIL mask_keep1 got %0d exp 0", obs_err); end
        keep[10] = 4'b1111;
        send_frame(WORDS, 0, 1'b0);
        checks++; if (obs_err !== 16'd24) begin errors++; $display("FAIL mask_keepall got %0d exp 24", obs_err); end
        checks++; if (total_err_bits !== 32'(m_err_bits)) begin errors++; $display("FAIL mask_total got %0d exp %0d", total_err_bits, m_err_bits); end
    endtask

    task automatic test_gaps_clear();
        logic [15:0] ref_err;
        clear_pattern();
        for (int k = 0; k < 8; k++) begin
            int w = $urandom_range(0, WORDS - 1);
            flip[w] = $urandom; keep[w] = 4'($urandom_range(0, 15));
        end
        send_frame(WORDS, 0, 1'b0);
        ref_err = obs_err;
        checks++; if (obs_err !== 16'(exp_err)) begin errors++; $display("FAIL rand_nogap got %0d exp %0d", obs_err, exp_err); end
        send_frame(WORDS, 40, 1'b0);
        checks++; if (obs_err !== ref_err || obs_err !== 16'(exp_err)) begin errors++; $display("FAIL rand_gaps got %0d exp %0d", obs_err, exp_err); end
        checks++; if (total_err_bits !== 32'(m_err_bits) || total_frames !== 32'(m_frames)) begin errors++; $display("FAIL rand_totals got %0d/%0d exp %0d/%0d", total_err_bits, total_frames, m_err_bits, m_frames); end
        send_frame(WORDS, 20, 1'b1);
        checks++; if ({total_frames, total_err_bits, err_frames} !== 96'd0) begin errors++; $display("FAIL clr_totals got %h exp 0", {total_frames, total_err_bits, err_frames}); end
        checks++; if (obs_err !== 16'(exp_err)) begin errors++; $display("FAIL clr_frame_bits got %0d exp %0d", obs_err, exp_err); end
    endtask

    task automatic test_midframe_reset();
        bit seen = 1'b0;
        clear_pattern();
        for (int w = 0; w < 20; w++) put_beat(model_word(w), 4'hF, 1'b0);
        arst_n = 1'b0;
        m_frames = 0; m_err_bits = 0; m_err_frames = 0;
        repeat (5) begin @(negedge clk); if (frame_done) seen = 1'b1; end
        checks++; if (seen || tready !== 1'b0 || total_frames !== 32'd0) begin errors++; $display("FAIL midreset got done %b tready %b frames %0d exp 0 0 0", seen, tready, total_frames); end
        arst_n = 1'b1;
        @(posedge clk); #1;
        send_frame(WORDS, 0, 1'b0);
        checks++; if (obs_err !== 16'd0 || obs_len !== 1'b0 || total_frames !== 32'd1) begin errors++; $display("FAIL after_midreset got err %0d len %b frames %0d exp 0 0 1", obs_err, obs_len, total_frames); end
    endtask

    initial begin
        build_prbs();
        clear_pattern();
        test_reset();
        test_gen();
        test_clean();
        test_errors();
        test_short();
        test_mask();
        test_gaps_clear();
        test_midframe_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
